mem_bus_responder: RTL and testbench

Memory-side responder for the 8-bit CPU core's memory bus. It accepts single-byte read/write requests from the CPU (address, write data, write enable), inserts a configurable number of wait states, performs the access on a 256×8 internal RAM, and returns read data with a one-cycle ready pulse. It is the target end of the CPU's `mem_addr` / `mem_data_out` / `mem_data_in` path and sits directly beside the core at the top level.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_resp_ram.sv | 26 ++
 rtl/mem_bus_responder.sv | 118 +++++++++++
 tb/tb_mem_bus_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus responder and its RAM.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam logic [MEM_ADDR_W-1:0] ROM_BASE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for addresses inside the read-only window at the top of the map.
  function automatic logic is_rom(input logic [MEM_ADDR_W-1:0] a);
    return (a >= ROM_BASE);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// 256x8 synchronous RAM: write and registered read on the same rising edge.
// No reset; the read returns the pre-write contents on an address collision.
module mem_resp_ram
  import mem_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic [MEM_DATA_W-1:0] i_wdata,
  output logic [MEM_DATA_W-1:0] o_rdata
);

  logic [MEM_DATA_W-1:0] r_mem [2**MEM_ADDR_W];
  logic [MEM_DATA_W-1:0] r_q;

  // Array write and registered read port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU bus: IDLE/WAIT/RESP FSM with WAIT_STATES
// extra cycles per access. Define MEM_RESP_ROM_EN to write-protect 8'hF0-8'hFF.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_e                r_state;
  logic [CW-1:0]         r_cnt;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic                  r_we;
  logic [MEM_DATA_W-1:0] r_wdata;
  logic [MEM_DATA_W-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_access;
  logic                  w_prot;
  logic                  w_ram_we;
  logic [MEM_ADDR_W-1:0] w_ram_addr;
  logic [MEM_DATA_W-1:0] w_ram_q;

  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);

`ifdef MEM_RESP_ROM_EN
  assign w_prot = is_rom(r_addr);
`else
  assign w_prot = 1'b0;
`endif

  // Gated by rst_n so a pending write is dropped when reset lands on the access edge.
  assign w_ram_we   = rst_n && w_access && r_we && !w_prot;
  // The RAM is read from the IDLE sample edge onward, so its output is settled by the access edge.
  assign w_ram_addr = (r_state == ST_IDLE) ? addr : r_addr;

  mem_resp_ram u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // Request FSM, wait counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= 8'h00;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            r_cnt   <= CW'(WAIT_STATES);
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_ready <= 1'b1;
            r_err   <= r_we && w_prot;
            r_rdata <= (r_we && !w_prot) ? r_wdata : w_ram_q;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: three instances with WAIT_STATES 0, 1 and 3.
// Define MEM_RESP_ROM_EN to exercise the write-protected window.
module tb_mem_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we_s = 1'b0;
  logic [7:0] addr_s = 8'h00;
  logic [7:0] wdata_s = 8'h00;
  logic       req_v [3];
  logic       rdy_v [3];
  logic       busy_v [3];
  logic       err_v [3];
  logic [7:0] rd_v [3];
  int         ws_of [3] = '{0, 1, 3};
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
    .rdata(rd_v[0]), .ready(rdy_v[0]), .busy(busy_v[0]), .err(err_v[0]));

  mem_bus_responder #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
    .rdata(rd_v[1]), .ready(rdy_v[1]), .busy(busy_v[1]), .err(err_v[1]));

  mem_bus_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
    .rdata(rd_v[2]), .ready(rdy_v[2]), .busy(busy_v[2]), .err(err_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on instance i, called at a negedge; returns at a negedge in IDLE.
  task automatic do_access(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] exp_d, input logic exp_e, input string tag);
    bit seen = 1'b0;
    we_s = w; addr_s = a; wdata_s = d; req_v[i] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_busy_rise"}, 32'(busy_v[i]), 32'd1);
      if (rdy_v[i]) begin
        seen = 1'b1;
        chk({tag, "_latency"}, 32'(k - 1), 32'(ws_of[i] + 1));
        chk({tag, "_rdata"}, 32'(rd_v[i]), 32'(exp_d));
        chk({tag, "_err"}, 32'(err_v[i]), 32'(exp_e));
        req_v[i] = 1'b0;
        break;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      req_v[i] = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ready_width"}, 32'(rdy_v[i]), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy_v[i]), 32'd0);
    chk({tag, "_err_clear"}, 32'(err_v[i]), 32'd0);
  endtask

  initial begin
    int got_n;
    int t1;
    int t2;
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_ready", i), 32'(rdy_v[i]), 32'd0);
      chk($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst%0d_rdata", i), 32'(rd_v[i]), 32'h00);
      chk($sformatf("rst%0d_err", i), 32'(err_v[i]), 32'd0);
    end

    // WAIT_STATES=1: write then read back, write echoes wdata
    do_access(1, 1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, "ws1_w10");
    do_access(1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "ws1_r10");
    do_access(1, 1'b1, 8'h01, 8'h5A, 8'h5A, 1'b0, "ws1_w01");
    do_access(1, 1'b1, 8'h02, 8'hC3, 8'hC3, 1'b0, "ws1_w02");

    // Latency sweep on WAIT_STATES=0 and 3
    do_access(0, 1'b1, 8'h30, 8'h66, 8'h66, 1'b0, "ws0_w30");
    do_access(0, 1'b0, 8'h30, 8'h00, 8'h66, 1'b0, "ws0_r30");
    do_access(2, 1'b1, 8'h20, 8'h77, 8'h77, 1'b0, "ws3_w20");

    // Back-to-back reads with req held high: pulses WAIT_STATES+3 = 4 cycles apart
    got_n = 0; t1 = 0; t2 = 0;
    we_s = 1'b0; addr_s = 8'h01; req_v[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rdy_v[1]) begin
        if (got_n == 0) begin
          chk("b2b_first_rdata", 32'(rd_v[1]), 32'h5A);
          t1 = cyc;
          addr_s = 8'h02;
        end else begin
          chk("b2b_second_rdata", 32'(rd_v[1]), 32'hC3);
          t2 = cyc;
          req_v[1] = 1'b0;
        end
        got_n++;
        if (got_n == 2) break;
      end
    end
    req_v[1] = 1'b0;
    chk("b2b_pulse_count", 32'(got_n), 32'd2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd4);
    @(negedge clk);
    @(negedge clk);

    // Reset in the second WAIT cycle drops the pending write of 3C
    we_s = 1'b1; addr_s = 8'h20; wdata_s = 8'h3C; req_v[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy_v[2]), 32'd0);
    chk("midrst_busy", 32'(busy_v[2]), 32'd0);
    chk("midrst_rdata", 32'(rd_v[2]), 32'h00);
    do_access(2, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0, "ws3_r20");

`ifdef MEM_RESP_ROM_EN
    u_dut1.u_ram.r_mem[8'hF4] = 8'h11;
    @(negedge clk);
    do_access(1, 1'b1, 8'hF4, 8'h99, 8'h11, 1'b1, "rom_wF4");
    do_access(1, 1'b0, 8'hF4, 8'h00, 8'h11, 1'b0, "rom_rF4");
`else
    do_access(1, 1'b1, 8'hF4, 8'h99, 8'h99, 1'b0, "ram_wF4");
    do_access(1, 1'b0, 8'hF4, 8'h00, 8'h99, 1'b0, "ram_rF4");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
